// File: rtl/carbon_sys16_bus_arbiter_if.sv
// Bus bundle for the sys16 arbiter: two requester channels (m0 = CPU, m1 = CarbonDMA)
// and one shared target channel. The arbiter connects through the master modport.
interface carbon_sys16_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  // Handshake rules: a request transfers on a cycle where req_valid && req_ready are both 1.
  // The initiator holds valid and every req_* field stable until that cycle. Responses are
  // single-cycle rsp_valid pulses with no backpressure.
  logic              m0_req_valid;
  logic              m0_req_ready;
  logic [ADDR_W-1:0] m0_req_addr;
  logic              m0_req_write;
  logic [31:0]       m0_req_wdata;
  logic [3:0]        m0_req_wstrb;
  logic              m0_rsp_valid;
  logic [31:0]       m0_rsp_rdata;
  logic              m0_rsp_err;

  logic              m1_req_valid;
  logic              m1_req_ready;
  logic [ADDR_W-1:0] m1_req_addr;
  logic              m1_req_write;
  logic [31:0]       m1_req_wdata;
  logic [3:0]        m1_req_wstrb;
  logic              m1_rsp_valid;
  logic [31:0]       m1_rsp_rdata;
  logic              m1_rsp_err;

  logic              s_req_valid;
  logic              s_req_ready;
  logic [6:0]        s_req_sel;
  logic [ADDR_W-1:0] s_req_addr;
  logic              s_req_write;
  logic [31:0]       s_req_wdata;
  logic [3:0]        s_req_wstrb;
  logic              s_rsp_valid;
  logic [31:0]       s_rsp_rdata;
  logic              s_rsp_err;

  modport master (
    input  m0_req_valid, m0_req_addr, m0_req_write, m0_req_wdata, m0_req_wstrb,
    output m0_req_ready, m0_rsp_valid, m0_rsp_rdata, m0_rsp_err,
    input  m1_req_valid, m1_req_addr, m1_req_write, m1_req_wdata, m1_req_wstrb,
    output m1_req_ready, m1_rsp_valid, m1_rsp_rdata, m1_rsp_err,
    output s_req_valid, s_req_sel, s_req_addr, s_req_write, s_req_wdata, s_req_wstrb,
    input  s_req_ready, s_rsp_valid, s_rsp_rdata, s_rsp_err
  );

  modport slave (
    output m0_req_valid, m0_req_addr, m0_req_write, m0_req_wdata, m0_req_wstrb,
    input  m0_req_ready, m0_rsp_valid, m0_rsp_rdata, m0_rsp_err,
    output m1_req_valid, m1_req_addr, m1_req_write, m1_req_wdata, m1_req_wstrb,
    input  m1_req_ready, m1_rsp_valid, m1_rsp_rdata, m1_rsp_err,
    input  s_req_valid, s_req_sel, s_req_addr, s_req_write, s_req_wdata, s_req_wstrb,
    output s_req_ready, s_rsp_valid, s_rsp_rdata, s_rsp_err
  );
endinterface

// File: rtl/carbon_sys16_bus_arbiter.sv
// Two-requester round-robin arbiter for the sys16 bus: decodes the granted address,
// runs one target transaction at a time with a timeout, and returns the response.
module carbon_sys16_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  carbon_sys16_bus_arbiter_if.master    bus,
  output logic [1:0]                    dbg_state
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [16:0] TO_LIM = 17'(TIMEOUT_CYCLES);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;   // 0 = m0, 1 = m1
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [6:0]        sel_q, sel_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;

  logic              grant0, grant1;
  logic [ADDR_W-1:0] mux_addr;
  logic              mux_write;
  logic [31:0]       mux_wdata;
  logic [3:0]        mux_wstrb;
  logic [6:0]        mux_sel;
  logic              timeout_hit;
  logic              rsp0, rsp1;

  // First hit wins; an all-zero result marks an out-of-map address.
  function automatic logic [6:0] decode(input logic [ADDR_W-1:0] a);
    logic [15:0] lo;
    logic        hi_nz;
    lo     = a[15:0];
    hi_nz  = |(a >> 16);
    decode = 7'b0000000;
    if (!hi_nz) begin
      if (lo[15:8] == 8'h00)                     decode = 7'b0000001;
      else if (lo[15:8] == 8'hF0)                decode = 7'b0000010;
      else if (lo[15:8] == 8'hF1)                decode = 7'b0000100;
      else if (lo[15:8] == 8'hF2)                decode = 7'b0001000;
      else if (lo[15:8] == 8'hF3)                decode = 7'b0010000;
      else if (lo >= 16'h8000 && lo <= 16'hBFFF) decode = 7'b0100000;
      else                                       decode = 7'b1000000;
    end
  endfunction

  // On a tie the requester that did not win last time goes first.
  assign grant0 = (state_q == IDLE) && bus.m0_req_valid && (!bus.m1_req_valid || last_q);
  assign grant1 = (state_q == IDLE) && bus.m1_req_valid && (!bus.m0_req_valid || !last_q);

  assign mux_addr  = grant1 ? bus.m1_req_addr  : bus.m0_req_addr;
  assign mux_write = grant1 ? bus.m1_req_write : bus.m0_req_write;
  assign mux_wdata = grant1 ? bus.m1_req_wdata : bus.m0_req_wdata;
  assign mux_wstrb = grant1 ? bus.m1_req_wstrb : bus.m0_req_wstrb;
  assign mux_sel   = decode(mux_addr);

  assign timeout_hit = ({1'b0, cnt_q} + 17'd1) == TO_LIM;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          owner_d = grant1;
          last_d  = grant1;
          addr_d  = mux_addr;
          write_d = mux_write;
          wdata_d = mux_wdata;
          wstrb_d = mux_wstrb;
          sel_d   = mux_sel;
          rdata_d = 32'h0;
          cnt_d   = 16'h0;
          err_d   = (mux_sel == 7'b0000000);
          state_d = (mux_sel == 7'b0000000) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 16'd1;
        if (bus.s_req_ready) begin
          if (bus.s_rsp_valid) begin
            rdata_d = bus.s_rsp_rdata;
            err_d   = bus.s_rsp_err;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end else if (timeout_hit) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // A response landing on the timeout cycle still counts as a real answer.
        if (bus.s_rsp_valid) begin
          rdata_d = bus.s_rsp_rdata;
          err_d   = bus.s_rsp_err;
          state_d = RESP;
        end else if (timeout_hit) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      sel_q   <= 7'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp0 = (state_q == RESP) && !owner_q;
  assign rsp1 = (state_q == RESP) && owner_q;

  assign bus.m0_req_ready = grant0;
  assign bus.m1_req_ready = grant1;
  assign bus.m0_rsp_valid = rsp0;
  assign bus.m1_rsp_valid = rsp1;
  assign bus.m0_rsp_rdata = rsp0 ? rdata_q : 32'h0;
  assign bus.m1_rsp_rdata = rsp1 ? rdata_q : 32'h0;
  assign bus.m0_rsp_err   = rsp0 && err_q;
  assign bus.m1_rsp_err   = rsp1 && err_q;

  assign bus.s_req_valid = (state_q == ISSUE);
  assign bus.s_req_sel   = sel_q;
  assign bus.s_req_addr  = addr_q;
  assign bus.s_req_write = write_q;
  assign bus.s_req_wdata = wdata_q;
  assign bus.s_req_wstrb = wstrb_q;

  assign dbg_state = state_q;

endmodule
